// File: rtl/core_wb_align_s_if.sv
// Write-back stage bundle: memory-stage handshake, candidate results,
// L1D return path and register-file write port.
interface core_wb_align_s_if #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
);
   logic                  wb_valid_in;
   logic                  wb_ready_out;
   logic                  wb_stall_out;
   logic                  wb_we_in;
   logic [REG_ADDR_W-1:0] wb_rd_in;
   logic [1:0]            wb_src_in;
   logic [2:0]            wb_sx_op_in;
   logic [1:0]            wb_addr_lo_in;
   logic [XLEN-1:0]       wb_alu_result_in;
   logic [XLEN-1:0]       wb_sx_imm_in;
   logic [XLEN-1:0]       wb_pc_4_in;
   logic [XLEN-1:0]       wb_mem_data_in;
   logic                  wb_ack_from_lid_in;
   logic                  wb_we_reg_file_out;
   logic [REG_ADDR_W-1:0] wb_rd_out;
   logic [XLEN-1:0]       wb_data_out;
   logic                  wb_err_out;

   modport master (
      output wb_valid_in, wb_we_in, wb_rd_in, wb_src_in,
      output wb_sx_op_in, wb_addr_lo_in, wb_alu_result_in,
      output wb_sx_imm_in, wb_pc_4_in, wb_mem_data_in,
      output wb_ack_from_lid_in,
      input  wb_ready_out, wb_stall_out, wb_we_reg_file_out,
      input  wb_rd_out, wb_data_out, wb_err_out
   );

   modport slave (
      input  wb_valid_in, wb_we_in, wb_rd_in, wb_src_in,
      input  wb_sx_op_in, wb_addr_lo_in, wb_alu_result_in,
      input  wb_sx_imm_in, wb_pc_4_in, wb_mem_data_in,
      input  wb_ack_from_lid_in,
      output wb_ready_out, wb_stall_out, wb_we_reg_file_out,
      output wb_rd_out, wb_data_out, wb_err_out
   );
endinterface

// File: rtl/core_wb_align_s.sv
// Write-back stage: result select, load alignment/extension and
// outstanding-load tracking with timeout abort.
module core_wb_align_s #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5,
   parameter int TIMEOUT    = 255
) (
   input logic              clk,
   input logic              rst,
   core_wb_align_s_if.slave wb
);
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [1:0] SRC_ALU = 2'd0;
   localparam logic [1:0] SRC_MEM = 2'd1;
   localparam logic [1:0] SRC_IMM = 2'd2;

   typedef enum logic {IDLE, WAIT_ACK} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q;
   logic                  h_we_q;
   logic [REG_ADDR_W-1:0] h_rd_q;
   logic [2:0]            h_op_q;
   logic [1:0]            h_off_q;
   logic                  we_q, err_q;
   logic [REG_ADDR_W-1:0] rd_q;
   logic [XLEN-1:0]       data_q;

   logic                  acc, wr, wr_we, err_d;
   logic                  hold, cnt_clr, cnt_inc;
   logic [REG_ADDR_W-1:0] wr_rd;
   logic [XLEN-1:0]       wr_data;

   function automatic logic [XLEN-1:0] align(
      input logic [XLEN-1:0] mem,
      input logic [2:0]      op,
      input logic [1:0]      off
   );
      logic [31:0] w;
      logic [7:0]  b;
      logic [15:0] h;
      w = mem[31:0];
      b = w[8*off +: 8];
      h = w[16*off[1] +: 16];
      case (op)
         3'd1:    align = XLEN'($signed(b));
         3'd2:    align = XLEN'(b);
         3'd3:    align = XLEN'($signed(h));
         3'd4:    align = XLEN'(h);
         default: align = XLEN'($signed(w));
      endcase
   endfunction

   assign acc             = wb.wb_valid_in && (state_q == IDLE);
   assign wb.wb_ready_out = (state_q == IDLE);
   assign wb.wb_stall_out = (state_q != IDLE);
   assign wb.wb_we_reg_file_out = we_q;
   assign wb.wb_rd_out    = rd_q;
   assign wb.wb_data_out  = data_q;
   assign wb.wb_err_out   = err_q;

   always_comb begin
      state_d = state_q;
      wr      = 1'b0;
      wr_we   = wb.wb_we_in;
      wr_rd   = wb.wb_rd_in;
      wr_data = '0;
      err_d   = 1'b0;
      hold    = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (acc) begin
               unique case (1'b1)
                  (wb.wb_src_in == SRC_ALU): begin
                     wr      = 1'b1;
                     wr_data = wb.wb_alu_result_in;
                  end
                  (wb.wb_src_in == SRC_IMM): begin
                     wr      = 1'b1;
                     wr_data = wb.wb_sx_imm_in;
                  end
                  (wb.wb_src_in == SRC_MEM): begin
                     if (wb.wb_ack_from_lid_in) begin
                        wr      = 1'b1;
                        wr_data = align(wb.wb_mem_data_in,
                                        wb.wb_sx_op_in,
                                        wb.wb_addr_lo_in);
                     end else begin
                        hold    = 1'b1;
                        cnt_clr = 1'b1;
                        state_d = WAIT_ACK;
                     end
                  end
                  default: begin
                     wr      = 1'b1;
                     wr_data = wb.wb_pc_4_in;
                  end
               endcase
            end
         end
         WAIT_ACK: begin
            if (wb.wb_ack_from_lid_in) begin
               wr      = 1'b1;
               wr_we   = h_we_q;
               wr_rd   = h_rd_q;
               wr_data = align(wb.wb_mem_data_in, h_op_q, h_off_q);
               state_d = IDLE;
            end else if (TIMEOUT != 0 &&
                         cnt_q == CW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         h_we_q  <= 1'b0;
         h_rd_q  <= '0;
         h_op_q  <= '0;
         h_off_q <= '0;
         we_q    <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         we_q    <= wr && wr_we && (wr_rd != '0);
         if (cnt_clr)
            cnt_q <= '0;
         else if (cnt_inc)
            cnt_q <= cnt_q + 1'b1;
         if (hold) begin
            h_we_q  <= wb.wb_we_in;
            h_rd_q  <= wb.wb_rd_in;
            h_op_q  <= wb.wb_sx_op_in;
            h_off_q <= wb.wb_addr_lo_in;
         end
         // rd/data follow every completion, even when the write is masked
         if (wr) begin
            rd_q   <= wr_rd;
            data_q <= wr_data;
         end
      end
   end
endmodule

// File: tb/tb_core_wb_align_s.sv
// Directed bench for core_wb_align_s: ALU stream, alignment,
// late ack, timeout, rd0/sources and reset during a pending load.
module tb_core_wb_align_s;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_vec = 0;
   int   n_err = 0;

   core_wb_align_s_if #(.XLEN(32), .REG_ADDR_W(5)) wb ();

   core_wb_align_s #(
      .XLEN(32), .REG_ADDR_W(5), .TIMEOUT(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .wb (wb)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      wb.wb_valid_in        = 1'b0;
      wb.wb_we_in           = 1'b0;
      wb.wb_rd_in           = '0;
      wb.wb_src_in          = '0;
      wb.wb_sx_op_in        = '0;
      wb.wb_addr_lo_in      = '0;
      wb.wb_alu_result_in   = '0;
      wb.wb_sx_imm_in       = '0;
      wb.wb_pc_4_in         = '0;
      wb.wb_mem_data_in     = '0;
      wb.wb_ack_from_lid_in = 1'b0;
   endtask

   task automatic drive(input logic [4:0] rd, input logic [1:0] src,
                        input logic [2:0] op, input logic [1:0] off,
                        input logic [31:0] val, input logic ack);
      wb.wb_valid_in        = 1'b1;
      wb.wb_we_in           = 1'b1;
      wb.wb_rd_in           = rd;
      wb.wb_src_in          = src;
      wb.wb_sx_op_in        = op;
      wb.wb_addr_lo_in      = off;
      wb.wb_alu_result_in   = (src == 2'd0) ? val : 32'hDEAD0000;
      wb.wb_sx_imm_in       = (src == 2'd2) ? val : 32'hDEAD0002;
      wb.wb_pc_4_in         = (src == 2'd3) ? val : 32'hDEAD0003;
      wb.wb_mem_data_in     = (src == 2'd1) ? val : 32'hDEAD0001;
      wb.wb_ack_from_lid_in = ack;
   endtask

   logic [1:0]  al_off [4] = '{2'd1, 2'd3, 2'd2, 2'd0};
   logic [2:0]  al_op  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
   logic [31:0] al_exp [4] = '{32'hFFFFFFA2, 32'h00000080,
                               32'hFFFF8091, 32'h0000A2B3};

   initial begin
      idle_in();
      rst = 1'b1;
      step();
      step();
      chk("rst_we",    wb.wb_we_reg_file_out, 0);
      chk("rst_rd",    wb.wb_rd_out, 0);
      chk("rst_data",  wb.wb_data_out, 0);
      chk("rst_err",   wb.wb_err_out, 0);
      rst = 1'b0;
      chk("rst_ready", wb.wb_ready_out, 1);
      chk("rst_stall", wb.wb_stall_out, 0);

      // back-to-back ALU writes
      for (int i = 0; i < 3; i++) begin
         drive(5'(3 + i), 2'd0, 3'd0, 2'd0, 32'(8'h11 * (i + 1)), 1'b0);
         step();
         chk("alu_we",    wb.wb_we_reg_file_out, 1);
         chk("alu_rd",    wb.wb_rd_out, 3 + i);
         chk("alu_data",  wb.wb_data_out, 32'h11 * (i + 1));
         chk("alu_ready", wb.wb_ready_out, 1);
      end
      idle_in();
      step();
      chk("alu_idle_we", wb.wb_we_reg_file_out, 0);

      // same-cycle ack alignment
      for (int i = 0; i < 4; i++) begin
         drive(5'd8, 2'd1, al_op[i], al_off[i], 32'h8091A2B3, 1'b1);
         step();
         chk("align_we",   wb.wb_we_reg_file_out, 1);
         chk("align_data", wb.wb_data_out, al_exp[i]);
      end
      idle_in();
      step();

      // late ack after 4 cycles
      drive(5'd7, 2'd1, 3'd1, 2'd0, 32'h0, 1'b0);
      step();
      idle_in();
      wb.wb_rd_in    = 5'd9;
      wb.wb_sx_op_in = 3'd2;
      for (int i = 0; i < 3; i++) begin
         chk("late_ready", wb.wb_ready_out, 0);
         chk("late_stall", wb.wb_stall_out, 1);
         chk("late_we",    wb.wb_we_reg_file_out, 0);
         step();
      end
      wb.wb_ack_from_lid_in = 1'b1;
      wb.wb_mem_data_in     = 32'h000000FF;
      chk("late_ready_ack", wb.wb_ready_out, 0);
      step();
      idle_in();
      chk("late_we",    wb.wb_we_reg_file_out, 1);
      chk("late_rd",    wb.wb_rd_out, 7);
      chk("late_data",  wb.wb_data_out, 32'hFFFFFFFF);
      chk("late_ready", wb.wb_ready_out, 1);
      step();
      chk("late_once", wb.wb_we_reg_file_out, 0);

      // timeout: err 9 cycles after accept
      drive(5'd11, 2'd1, 3'd0, 2'd0, 32'h0, 1'b0);
      step();
      idle_in();
      for (int i = 1; i <= 8; i++) begin
         chk("to_err_early", wb.wb_err_out, 0);
         chk("to_ready",     wb.wb_ready_out, 0);
         step();
      end
      chk("to_err",      wb.wb_err_out, 1);
      chk("to_ready_up", wb.wb_ready_out, 1);
      chk("to_no_we",    wb.wb_we_reg_file_out, 0);
      step();
      chk("to_err_once", wb.wb_err_out, 0);
      drive(5'd10, 2'd0, 3'd0, 2'd0, 32'h55, 1'b0);
      step();
      idle_in();
      chk("to_alu_we",   wb.wb_we_reg_file_out, 1);
      chk("to_alu_data", wb.wb_data_out, 32'h55);

      // rd0 masking and IMM / PC+4 sources
      drive(5'd0, 2'd2, 3'd0, 2'd0, 32'h1234, 1'b0);
      step();
      chk("rd0_we",   wb.wb_we_reg_file_out, 0);
      chk("rd0_rd",   wb.wb_rd_out, 0);
      chk("rd0_data", wb.wb_data_out, 32'h1234);
      drive(5'd1, 2'd3, 3'd1, 2'd3, 32'h100, 1'b0);
      step();
      idle_in();
      chk("pc4_we",   wb.wb_we_reg_file_out, 1);
      chk("pc4_rd",   wb.wb_rd_out, 1);
      chk("pc4_data", wb.wb_data_out, 32'h100);

      // ack in IDLE without accept is ignored
      wb.wb_ack_from_lid_in = 1'b1;
      wb.wb_mem_data_in     = 32'h77;
      step();
      idle_in();
      chk("stray_ack_we", wb.wb_we_reg_file_out, 0);

      // reset while waiting, then a late ack
      drive(5'd12, 2'd1, 3'd0, 2'd0, 32'h0, 1'b0);
      step();
      idle_in();
      step();
      chk("rw_ready", wb.wb_ready_out, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rw_ready_rst", wb.wb_ready_out, 1);
      chk("rw_we_rst",    wb.wb_we_reg_file_out, 0);
      wb.wb_ack_from_lid_in = 1'b1;
      wb.wb_mem_data_in     = 32'hCAFE;
      step();
      idle_in();
      chk("rw_we",   wb.wb_we_reg_file_out, 0);
      chk("rw_err",  wb.wb_err_out, 0);
      chk("rw_data", wb.wb_data_out, 0);
      for (int i = 0; i < 10; i++) step();
      chk("rw_err_late", wb.wb_err_out, 0);
      chk("rw_ready_end", wb.wb_ready_out, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/core_wb_align_s.md
# core_wb_align_s

Parametrised write-back stage for the Selen core pipeline, sitting between the memory stage and the register file. It accepts one instruction per cycle over a valid/ready handshake and selects the result source (ALU, load data, immediate, PC+4). Load data is byte-lane aligned by address offset and sign/zero extended to XLEN. It tracks an outstanding L1D load, stalls upstream until the ack arrives, and aborts with an error pulse if the ack does not arrive within a programmable timeout.

## Interface
- XLEN, 32, datapath width; legal values are 32 or 64.
- REG_ADDR_W, 5, register-file address width.
- TIMEOUT, 255, maximum cycles in WAIT_ACK before abort; 0 disables the timeout.
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- wb_valid_in  in  1  the memory stage presents an instruction.
- wb_ready_out  out  1  the stage accepts an instruction this cycle.
- wb_stall_out  out  1  equals ~wb_ready_out.
- wb_we_in  in  1  the instruction writes the register file.
- wb_rd_in  in  REG_ADDR_W  destination register.
- wb_src_in  in  2  result source: 0 = ALU, 1 = MEM, 2 = IMM, 3 = PC+4.
- wb_sx_op_in  in  3  load extension: 0 = W, 1 = B, 2 = UB, 3 = H, 4 = UH; 5–7 are treated as W.
- wb_addr_lo_in  in  2  load byte offset (address[1:0]).
- wb_alu_result_in, wb_sx_imm_in, wb_pc_4_in  in  XLEN each  candidate results.
- wb_mem_data_in  in  XLEN  L1D read data; valid only when ack is high.
- wb_ack_from_lid_in  in  1  L1D data-valid strobe.
- wb_we_reg_file_out  out  1  register-file write enable.
- wb_rd_out  out  REG_ADDR_W  register-file write address.
- wb_data_out  out  XLEN  register-file write data.
- wb_err_out  out  1  one-cycle pulse on load timeout.

## Operation
- An instruction is accepted when wb_valid_in && wb_ready_out. wb_ready_out = (state == IDLE).
- The FSM has two states: IDLE and WAIT_ACK.
- IDLE, accepted, wb_src_in != MEM: the result is registered and state stays IDLE.
- IDLE, accepted, wb_src_in == MEM with ack high in the same cycle: the aligned data is registered and state stays IDLE.
- IDLE, accepted, wb_src_in == MEM with ack low: we, rd, sx_op and addr_lo are latched into hold registers, the wait counter is cleared, and state goes to WAIT_ACK.
- WAIT_ACK with ack high: the data is aligned using the held fields, the write is registered, and state returns to IDLE.
- WAIT_ACK, ack low, counter == TIMEOUT-1 (TIMEOUT != 0): wb_err_out pulses on the next cycle, no register write occurs, and state returns to IDLE. Otherwise the counter increments.
- An ack that arrives while in IDLE with no MEM accept is ignored.
- Alignment:
  - B/UB selects byte mem[8*off +: 8].
  - H/UH selects halfword mem[16*off[1] +: 16]; off[0] is ignored.
  - W passes the low 32 bits. For XLEN = 64, W is sign-extended from bit 31.
  - B and H are sign-extended to XLEN; UB and UH are zero-extended.
- sx_op is applied only when src == MEM. ALU, IMM and PC+4 results pass through unchanged.
- wb_we_reg_file_out is forced to 0 when rd == 0. wb_data_out and wb_rd_out still update in that case.
- Reset mid-WAIT_ACK returns the FSM to IDLE and discards the pending load. A late ack after reset is ignored.

## Timing
- Reset values: state = IDLE, wait counter = 0, wb_we_reg_file_out = 0, wb_rd_out = 0, wb_data_out = 0, wb_err_out = 0. wb_ready_out is 1 in the first cycle after reset.
- Non-load instructions, and loads acked in the accept cycle: the write appears 1 cycle after accept, at a throughput of 1 per cycle.
- Late load: the write appears 1 cycle after the ack cycle. wb_ready_out is low from the cycle after accept up to and including the ack cycle.
- wb_we_reg_file_out is high for exactly one cycle per committed write, and is low in every cycle with no accept or ack completion.
- Timeout: wb_err_out rises TIMEOUT+1 cycles after accept (for example, 256 with the default). wb_ready_out returns high in the same cycle as the error pulse.
- wb_ready_out is purely state-decoded. It has no combinational path from wb_valid_in or ack.

## Test plan
- Back-to-back ALU writes: rd = 3, 4, 5 with data 0x11, 0x22, 0x33 over 3 consecutive cycles -> three one-cycle writes in consecutive cycles, 1-cycle latency, ready held high.
- Byte/half alignment with ack in the accept cycle and mem = 0x8091A2B3:
  - off = 1, B -> 0xFFFFFFA2
  - off = 3, UB -> 0x00000080
  - off = 2, H -> 0xFFFF8091
  - off = 0, UH -> 0x0000A2B3
- Late ack: a load is accepted with ack low, and ack arrives 4 cycles later with 0x000000FF, op B, rd = 7 -> ready is low for 4 cycles, then rd 7 is written with 0xFFFFFFFF one cycle after the ack.
- Timeout with TIMEOUT = 8: a load is accepted and never acked -> wb_err_out pulses once, 9 cycles after accept, no write occurs, and a subsequent ALU instruction commits normally.
- rd = 0 and sources: IMM 0x1234 to rd 0 -> no write enable. PC+4 0x100 to rd 1 -> written, with sx_op = B ignored.
- Reset in WAIT_ACK: assert rst for 1 cycle while waiting, then drive ack with data -> no write and no error, and ready is high after reset.
